program_load_controller: RTL and testbench

PROGRAM_LOAD_CONTROLLER -- requirements
Module: program_load_controller

---
 rtl/plc_pkg.sv | 6 +
 rtl/plc_timeout.sv | 18 +
 rtl/program_load_controller.sv | 139 +++++++++++++
 tb/tb_program_load_controller.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/plc_pkg.sv
// plc_pkg: shared FSM encoding and constants for the program load controller.
package plc_pkg;
  typedef enum logic [2:0] {IDLE, COUNT, HI, LO, CSUM, FILL, DONE, ERR} state_e;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int TIMEOUT_CYC_DEF = 1000000;
endpackage

// File: rtl/plc_timeout.sv
// plc_timeout: counts idle cycles while enabled; expired_o fires on the LIMIT-th idle cycle.
module plc_timeout #(
  parameter int LIMIT = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic expired_o
);
  localparam int W = $clog2(LIMIT + 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign cnt_d = (!en_i || clr_i) ? '0 : cnt_q + W'(1);
  assign expired_o = en_i && !clr_i && cnt_q == W'(LIMIT - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/program_load_controller.sv
// program_load_controller: loads a UART byte frame into instruction memory and releases the core.
// Define PLC_CHECKSUM_EN to require a trailing XOR checksum byte.
module program_load_controller
  import plc_pkg::*;
#(
  parameter int ADDR_W      = 5,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              CLK,
  input  logic              CPU_RESETN,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              cpu_run,
  output logic              load_done,
  output logic              err_frame,
  output logic              err_csum
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int W1 = ADDR_W + 1;
  state_e state_q, state_d, fin;
  logic [1:0] rs_q;
  logic rst_n, tmo, tmo_en;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [W1-1:0] cnt_q, cnt_d, widx_q, widx_d;
  logic [7:0] hi_q, hi_d, csum_q, csum_d;
  logic we_q, we_d, run_q, run_d, done_q, done_d, ef_q, ef_d, ec_q, ec_d;
  // reset asserts immediately but releases only after two clean clock edges
  always_ff @(posedge CLK or negedge CPU_RESETN)
    if (!CPU_RESETN) rs_q <= '0;
    else rs_q <= {rs_q[0], 1'b1};
  assign rst_n = rs_q[1];
  assign tmo_en = state_q inside {COUNT, HI, LO, CSUM};
  plc_timeout #(.LIMIT(TIMEOUT_CYC)) u_tmo (
    .clk(CLK), .rst_n(rst_n), .en_i(tmo_en), .clr_i(rx_valid), .expired_o(tmo)
  );
  assign fin = (cnt_q == W1'(DEPTH)) ? DONE : FILL;
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    we_d = 1'b0;
    cnt_d = cnt_q;
    widx_d = widx_q;
    hi_d = hi_q;
    csum_d = csum_q;
    run_d = run_q;
    done_d = done_q;
    ef_d = ef_q;
    ec_d = ec_q;
    case (state_q)
      IDLE, DONE, ERR: begin
        run_d = state_q == DONE;
        done_d = state_q == DONE;
        if (rx_valid && rx_data == SYNC_BYTE) begin
          state_d = COUNT;
          {ef_d, ec_d, done_d, run_d} = '0;
          addr_d = '0;
          widx_d = '0;
          csum_d = '0;
        end
      end
      COUNT: if (rx_valid) begin
        if (rx_data == 8'd0 || 32'(rx_data) > DEPTH) begin
          state_d = ERR;
          ef_d = 1'b1;
        end else begin
          cnt_d = W1'(rx_data);
          state_d = HI;
        end
      end
      HI: if (rx_valid) begin
        hi_d = rx_data;
        csum_d = csum_q ^ rx_data;
        state_d = LO;
      end
      LO: if (rx_valid) begin
        we_d = 1'b1;
        addr_d = widx_q[ADDR_W-1:0];
        wdata_d = {hi_q, rx_data};
        csum_d = csum_q ^ rx_data;
        widx_d = widx_q + W1'(1);
`ifdef PLC_CHECKSUM_EN
        state_d = (widx_q + W1'(1) == cnt_q) ? CSUM : HI;
`else
        state_d = (widx_q + W1'(1) == cnt_q) ? fin : HI;
`endif
      end
      CSUM: if (rx_valid) begin
        state_d = (rx_data == csum_q) ? fin : ERR;
        ec_d = rx_data != csum_q;
      end
      FILL: begin
        we_d = 1'b1;
        addr_d = widx_q[ADDR_W-1:0];
        wdata_d = '0;
        widx_d = widx_q + W1'(1);
        state_d = (widx_q == W1'(DEPTH - 1)) ? DONE : FILL;
      end
      default: state_d = IDLE;
    endcase
    if (tmo) begin
      state_d = ERR;
      ef_d = 1'b1;
    end
  end
  always_ff @(posedge CLK or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      we_q <= 1'b0;
      cnt_q <= '0;
      widx_q <= '0;
      hi_q <= '0;
      csum_q <= '0;
      {run_q, done_q, ef_q, ec_q} <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      we_q <= we_d;
      cnt_q <= cnt_d;
      widx_q <= widx_d;
      hi_q <= hi_d;
      csum_q <= csum_d;
      {run_q, done_q, ef_q, ec_q} <= {run_d, done_d, ef_d, ec_d};
    end
  assign imem_we = we_q;
  assign imem_addr = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_run = run_q;
  assign load_done = done_q;
  assign err_frame = ef_q;
  assign err_csum = ec_q;
endmodule

// File: tb/tb_program_load_controller.sv
// tb_program_load_controller: table, random and hand-written frame checks against a write-list model.
module tb_program_load_controller;
  localparam int AW = 5;
  localparam int D = 32;
  localparam int T = 40;
`ifdef PLC_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif
  typedef struct {
    logic [7:0] cnt;
    bit bad, stray, run, done, ef, ec;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0, rx_valid = 1'b0;
  logic [7:0] rx_data = '0;
  logic imem_we, cpu_run, load_done, err_frame, err_csum;
  logic [AW-1:0] imem_addr;
  logic [15:0] imem_wdata;
  int n_chk = 0, n_fail = 0;
  logic [20:0] got_q[$], exp_q[$];
  vec_t tbl[9];

  always #5 clk = ~clk;

  program_load_controller #(.ADDR_W(AW), .TIMEOUT_CYC(T)) dut (
    .CLK(clk), .CPU_RESETN(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_run(cpu_run), .load_done(load_done), .err_frame(err_frame), .err_csum(err_csum)
  );

  always @(negedge clk) if (imem_we) got_q.push_back({imem_addr, imem_wdata});

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic chk_outs(input string nm, input bit run, input bit done, input bit ef, input bit ec);
    chk({nm, ".cpu_run"}, 32'(cpu_run), 32'(run));
    chk({nm, ".load_done"}, 32'(load_done), 32'(done));
    chk({nm, ".err_frame"}, 32'(err_frame), 32'(ef));
    chk({nm, ".err_csum"}, 32'(err_csum), 32'(ec));
  endtask

  task automatic chk_writes(input string nm);
    int mism = 0;
    chk({nm, ".nwrites"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) mism++;
    chk({nm, ".write_mismatches"}, mism, 0);
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    repeat (gap) @(posedge clk);
    @(posedge clk);
    #1 rx_valid = 1'b1;
    rx_data = b;
    @(posedge clk);
    #1 rx_valid = 1'b0;
    rx_data = 8'($urandom);
  endtask

  // expected writes: every received word at its index, then zero-fill unless the checksum rejected it
  task automatic frame(input logic [7:0] cnt, input bit bad, input bit stray, input int gmax);
    logic [15:0] w;
    logic [7:0] cs = '0;
    got_q.delete();
    exp_q.delete();
    send(8'hA5, $urandom_range(gmax, 0));
    send(cnt, $urandom_range(gmax, 0));
    if (cnt >= 1 && int'(cnt) <= D) begin
      for (int i = 0; i < int'(cnt); i++) begin
        w = 16'($urandom);
        send(w[15:8], $urandom_range(gmax, 0));
        send(w[7:0], $urandom_range(gmax, 0));
        cs = cs ^ w[15:8] ^ w[7:0];
        exp_q.push_back({AW'(i), w});
      end
      if (CS) send(cs ^ (bad ? 8'h5A : 8'h00), $urandom_range(gmax, 0));
      if (!(CS && bad))
        for (int a = int'(cnt); a < D; a++) exp_q.push_back({AW'(a), 16'h0000});
      if (stray) begin
        repeat (2) @(posedge clk);
        send(8'hA5, 0);
      end
    end
    repeat (40) @(posedge clk);
    #1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w;
    logic [7:0] c, cs;
    bit bad, ok;
    tbl = '{
      '{8'd1,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0},
      '{8'd3,   1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0},
      '{8'd32,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0},
      '{8'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0},
      '{8'd33,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0},
      '{8'd255, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0},
      '{8'd5,   1'b1, 1'b0, !CS,  !CS,  1'b0, CS},
      '{8'd31,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0},
      '{8'd16,  1'b1, 1'b0, !CS,  !CS,  1'b0, CS}
    };
    repeat (3) @(posedge clk);
    #1;
    chk("reset.we", 32'(imem_we), 0);
    chk("reset.addr", 32'(imem_addr), 0);
    chk("reset.wdata", 32'(imem_wdata), 0);
    chk_outs("reset", 0, 0, 0, 0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // the reference frame: last LO byte must produce the write on the very next cycle
    got_q.delete();
    exp_q.delete();
    exp_q.push_back({5'd0, 16'h1234});
    exp_q.push_back({5'd1, 16'hABCD});
    for (int a = 2; a < D; a++) exp_q.push_back({AW'(a), 16'h0000});
    send(8'hA5, 0);
    send(8'h02, 0);
    send(8'h12, 0);
    send(8'h34, 0);
    send(8'hAB, 0);
    send(8'hCD, 0);
    chk("ref.we_pulse", 32'(imem_we), 1);
    chk("ref.addr", 32'(imem_addr), 1);
    chk("ref.wdata", 32'(imem_wdata), 32'h0000ABCD);
    if (CS) send(8'h40, 0);
    repeat (40) @(posedge clk);
    #1;
    chk_writes("ref");
    chk_outs("ref", 1, 1, 0, 0);
    chk("ref.addr_stops", 32'(imem_addr), D - 1);

    // non-sync bytes are ignored in DONE, sync drops cpu_run on the next cycle
    send(8'h12, 0);
    chk("done.ignore_run", 32'(cpu_run), 1);
    send(8'hA5, 0);
    chk("done.resync_run", 32'(cpu_run), 0);
    chk("done.resync_done", 32'(load_done), 0);

    // full-depth frame skips fill; cpu_run follows one cycle after the finishing byte's effect
    got_q.delete();
    exp_q.delete();
    cs = '0;
    send(8'd32, 0);
    for (int i = 0; i < D; i++) begin
      w = 16'($urandom);
      exp_q.push_back({AW'(i), w});
      cs = cs ^ w[15:8] ^ w[7:0];
      send(w[15:8], 0);
      send(w[7:0], 0);
    end
    chk("full.last_we", 32'(imem_we), 1);
    chk("full.last_addr", 32'(imem_addr), D - 1);
    chk("full.run_not_yet", 32'(cpu_run), 0);
`ifdef PLC_CHECKSUM_EN
    send(cs, 0);
    chk("full.run_after_csum", 32'(cpu_run), 0);
`endif
    @(posedge clk);
    #1;
    chk("full.run_next", 32'(cpu_run), 1);
    chk("full.we_low", 32'(imem_we), 0);
    repeat (40) @(posedge clk);
    #1;
    chk_writes("full");

`ifdef PLC_CHECKSUM_EN
    got_q.delete();
    exp_q.delete();
    exp_q.push_back({5'd0, 16'h1234});
    send(8'hA5, 0);
    send(8'h01, 0);
    send(8'h12, 0);
    send(8'h34, 0);
    send(8'h00, 0);
    repeat (40) @(posedge clk);
    #1;
    chk_writes("badcs");
    chk_outs("badcs", 0, 0, 0, 1);
    frame(8'd1, 1'b0, 1'b0, 0);
    chk_outs("badcs.recover", 1, 1, 0, 0);
`endif

    // idle timeout expires exactly TIMEOUT_CYC cycles after the last byte
    got_q.delete();
    send(8'hA5, 0);
    send(8'h02, 0);
    send(8'h12, 0);
    repeat (T - 1) @(posedge clk);
    #1;
    chk("tmo.before", 32'(err_frame), 0);
    @(posedge clk);
    #1;
    chk("tmo.at", 32'(err_frame), 1);
    repeat (5) @(posedge clk);
    #1;
    chk("tmo.nwrites", got_q.size(), 0);
    chk("tmo.run", 32'(cpu_run), 0);

    foreach (tbl[i]) begin
      frame(tbl[i].cnt, tbl[i].bad, tbl[i].stray, 2);
      chk_writes($sformatf("tbl%0d", i));
      chk_outs($sformatf("tbl%0d", i), tbl[i].run, tbl[i].done, tbl[i].ef, tbl[i].ec);
    end

    for (int k = 0; k < 15; k++) begin
      c = 8'($urandom_range(34, 0));
      bad = $urandom_range(3, 0) == 0;
      ok = c >= 1 && int'(c) <= D;
      frame(c, bad, 1'b0, 3);
      chk_writes($sformatf("rnd%0d", k));
      chk_outs($sformatf("rnd%0d", k), ok && !(CS && bad), ok && !(CS && bad), !ok, ok && CS && bad);
    end

    // reset in the middle of zero-fill clears outputs at once and stops writes
    send(8'hA5, 0);
    send(8'h01, 0);
    send(8'h12, 0);
    send(8'h34, 0);
    if (CS) send(8'h26, 0);
    repeat (5) @(posedge clk);
    #3;
    chk("mid.we_before", 32'(imem_we), 1);
    rst_n = 1'b0;
    #1;
    chk("mid.we", 32'(imem_we), 0);
    chk("mid.addr", 32'(imem_addr), 0);
    chk("mid.wdata", 32'(imem_wdata), 0);
    chk_outs("mid", 0, 0, 0, 0);
    got_q.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("mid.no_writes", got_q.size(), 0);
    chk("mid.run", 32'(cpu_run), 0);
    frame(8'd4, 1'b0, 1'b0, 1);
    chk_writes("post");
    chk_outs("post", 1, 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
